// File: rtl/mpi_eth_rx_parser_if.sv
// ============================================================================
//  Module      : mpi_eth_rx_parser_if
//  Description : AXI-stream bundle (64-bit data, byte keep, last, valid/ready)
//                used for the input and output streams of mpi_eth_rx_parser.
//                master drives DATA/KEEP/LAST/VALID and samples READY;
//                slave samples DATA/KEEP/LAST/VALID and drives READY.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mpi_eth_rx_parser_if;
  logic [63:0] DATA;
  logic [7:0]  KEEP;
  logic        LAST;
  logic        VALID;
  logic        READY;

  modport master (output DATA, output KEEP, output LAST, output VALID, input READY);
  modport slave  (input DATA, input KEEP, input LAST, input VALID, output READY);
endinterface

`default_nettype wire

// File: rtl/mpi_eth_rx_parser.sv
// ============================================================================
//  Module      : mpi_eth_rx_parser
//  Description : Strips a 3-beat Ethernet/MPI header from an AXI stream,
//                presents the parsed fields with a valid/ready handshake and
//                forwards the payload beats unchanged. Flags truncated headers
//                and payload byte counts that disagree with the size field.
//  Ports       : clk, aresetn (async, active-low)
//                stream_in  (slave)  - header + payload input stream
//                stream_out (master) - payload-only output stream
//                mac_dst/mac_src/dst_rank/src_rank/packet_type/size/tag
//                hdr_valid / hdr_ready - parsed field handshake
//                err_trunc / err_len   - single-cycle error pulses
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mpi_eth_rx_parser #(
  parameter int HDR_BEATS = 3
) (
  input  logic                       clk,
  input  logic                       aresetn,
  mpi_eth_rx_parser_if.slave         stream_in,
  mpi_eth_rx_parser_if.master        stream_out,
  output logic [47:0]                mac_dst,
  output logic [47:0]                mac_src,
  output logic [15:0]                dst_rank,
  output logic [7:0]                 src_rank,
  output logic [7:0]                 packet_type,
  output logic [31:0]                size,
  output logic [7:0]                 tag,
  output logic                       hdr_valid,
  input  logic                       hdr_ready,
  output logic                       err_trunc,
  output logic                       err_len
);

  localparam logic [2:0] c_st_hdr0    = 3'd0;
  localparam logic [2:0] c_st_hdr1    = 3'd1;
  // Final header beat; with the supported HDR_BEATS of 3 this encodes to 2.
  localparam logic [2:0] c_st_hdr2    = 3'(HDR_BEATS - 1);
  localparam logic [2:0] c_st_payload = 3'd3;
  localparam logic [2:0] c_st_drop    = 3'd4;

  localparam logic [7:0] c_type_reserved = 8'hFF;

  logic [2:0]  state_q,       state_d;
  logic [47:0] mac_dst_q,     mac_dst_d;
  logic [47:0] mac_src_q,     mac_src_d;
  logic [15:0] dst_rank_q,    dst_rank_d;
  logic [7:0]  src_rank_q,    src_rank_d;
  logic [7:0]  packet_type_q, packet_type_d;
  logic [31:0] size_q,        size_d;
  logic [7:0]  tag_q,         tag_d;
  logic        hdr_valid_q,   hdr_valid_d;
  logic        err_trunc_q,   err_trunc_d;
  logic        err_len_q,     err_len_d;
  logic [31:0] byte_cnt_q,    byte_cnt_d;

  logic        reserved;
  logic        in_ready;
  logic        in_accept;
  logic [31:0] beat_bytes;
  logic [31:0] byte_sum;

  // A reserved-type packet spends one cycle in PAYLOAD with both streams
  // closed, then DROP swallows the payload; no reserved beat ever leaks out.
  assign reserved = (packet_type_q == c_type_reserved);

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      c_st_hdr0:    in_ready = !(hdr_valid_q && !hdr_ready);
      c_st_hdr1,
      c_st_hdr2,
      c_st_drop:    in_ready = 1'b1;
      c_st_payload: in_ready = !reserved && stream_out.READY;
      default:      in_ready = 1'b0;
    endcase
  end

  // READY is forced low while reset is asserted, independent of the clock.
  assign stream_in.READY  = in_ready && aresetn;
  assign in_accept        = stream_in.VALID && stream_in.READY;

  assign stream_out.VALID = (state_q == c_st_payload) && !reserved && stream_in.VALID;
  assign stream_out.DATA  = stream_in.DATA;
  assign stream_out.KEEP  = stream_in.KEEP;
  assign stream_out.LAST  = stream_in.LAST;

  assign beat_bytes = 32'($countones(stream_in.KEEP));
  assign byte_sum   = byte_cnt_q + beat_bytes;

  always_comb begin
    state_d       = state_q;
    mac_dst_d     = mac_dst_q;
    mac_src_d     = mac_src_q;
    dst_rank_d    = dst_rank_q;
    src_rank_d    = src_rank_q;
    packet_type_d = packet_type_q;
    size_d        = size_q;
    tag_d         = tag_q;
    byte_cnt_d    = byte_cnt_q;
    err_trunc_d   = 1'b0;
    err_len_d     = 1'b0;
    hdr_valid_d   = hdr_valid_q && !hdr_ready;

    case (state_q)
      c_st_hdr0: begin
        if (in_accept) begin
          mac_dst_d        = stream_in.DATA[47:0];
          mac_src_d[15:0]  = stream_in.DATA[63:48];
          if (stream_in.LAST) begin
            err_trunc_d = 1'b1;
          end else begin
            state_d = c_st_hdr1;
          end
        end
      end
      c_st_hdr1: begin
        if (in_accept) begin
          mac_src_d[47:16] = stream_in.DATA[31:0];
          dst_rank_d       = stream_in.DATA[47:32];
          src_rank_d       = stream_in.DATA[55:48];
          packet_type_d    = stream_in.DATA[63:56];
          if (stream_in.LAST) begin
            err_trunc_d = 1'b1;
            state_d     = c_st_hdr0;
          end else begin
            state_d = c_st_hdr2;
          end
        end
      end
      c_st_hdr2: begin
        if (in_accept) begin
          size_d      = stream_in.DATA[31:0];
          tag_d       = stream_in.DATA[39:32];
          hdr_valid_d = 1'b1;
          byte_cnt_d  = 32'd0;
          if (stream_in.LAST) begin
            // Header-only packet: any non-zero size is a length error.
            err_len_d = (stream_in.DATA[31:0] != 32'd0);
            state_d   = c_st_hdr0;
          end else begin
            state_d = c_st_payload;
          end
        end
      end
      c_st_payload: begin
        if (reserved) begin
          state_d = c_st_drop;
        end else if (in_accept) begin
          byte_cnt_d = byte_sum;
          if (stream_in.LAST) begin
            err_len_d = (byte_sum != size_q);
            state_d   = c_st_hdr0;
          end
        end
      end
      c_st_drop: begin
        if (in_accept && stream_in.LAST) begin
          state_d = c_st_hdr0;
        end
      end
      default: state_d = c_st_hdr0;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= c_st_hdr0;
      mac_dst_q     <= '0;
      mac_src_q     <= '0;
      dst_rank_q    <= '0;
      src_rank_q    <= '0;
      packet_type_q <= '0;
      size_q        <= '0;
      tag_q         <= '0;
      hdr_valid_q   <= 1'b0;
      err_trunc_q   <= 1'b0;
      err_len_q     <= 1'b0;
      byte_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      mac_dst_q     <= mac_dst_d;
      mac_src_q     <= mac_src_d;
      dst_rank_q    <= dst_rank_d;
      src_rank_q    <= src_rank_d;
      packet_type_q <= packet_type_d;
      size_q        <= size_d;
      tag_q         <= tag_d;
      hdr_valid_q   <= hdr_valid_d;
      err_trunc_q   <= err_trunc_d;
      err_len_q     <= err_len_d;
      byte_cnt_q    <= byte_cnt_d;
    end
  end

  assign mac_dst     = mac_dst_q;
  assign mac_src     = mac_src_q;
  assign dst_rank    = dst_rank_q;
  assign src_rank    = src_rank_q;
  assign packet_type = packet_type_q;
  assign size        = size_q;
  assign tag         = tag_q;
  assign hdr_valid   = hdr_valid_q;
  assign err_trunc   = err_trunc_q;
  assign err_len     = err_len_q;

endmodule

`default_nettype wire

// File: tb/tb_mpi_eth_rx_parser.sv
// ============================================================================
//  Module      : tb_mpi_eth_rx_parser
//  Description : Scoreboard bench for mpi_eth_rx_parser. Packets are built as
//                beat lists, a packet-level model derives the expected header,
//                payload beats and error pulses, and a monitor compares what
//                the DUT presents against those queues.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mpi_eth_rx_parser;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] dr;
    logic [7:0]  sr;
    logic [7:0]  ty;
    logic [31:0] sz;
    logic [7:0]  tg;
  } hdr_t;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  mpi_eth_rx_parser_if s_in ();
  mpi_eth_rx_parser_if s_out ();

  logic [47:0] mac_dst, mac_src;
  logic [15:0] dst_rank;
  logic [7:0]  src_rank, packet_type, tag;
  logic [31:0] size;
  logic        hdr_valid, hdr_ready, err_trunc, err_len;

  mpi_eth_rx_parser #(.HDR_BEATS(3)) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .stream_in   (s_in),
    .stream_out  (s_out),
    .mac_dst     (mac_dst),
    .mac_src     (mac_src),
    .dst_rank    (dst_rank),
    .src_rank    (src_rank),
    .packet_type (packet_type),
    .size        (size),
    .tag         (tag),
    .hdr_valid   (hdr_valid),
    .hdr_ready   (hdr_ready),
    .err_trunc   (err_trunc),
    .err_len     (err_len)
  );

  int checks = 0;
  int errors = 0;
  int exp_trunc = 0, exp_len = 0, seen_trunc = 0, seen_len = 0;
  hdr_t  hq[$];
  beat_t bq[$];
  logic [63:0] pd[$];
  logic [7:0]  pk[$];

  // 0: hold low, 1: hold high, 2: toggle every cycle, other: random
  int hdr_mode = 1;
  int out_mode = 1;

  task automatic chk(input string nm, input logic [167:0] act, input logic [167:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (hdr_mode)
      0:       hdr_ready = 1'b0;
      1:       hdr_ready = 1'b1;
      2:       hdr_ready = ~hdr_ready;
      default: hdr_ready = 1'($urandom_range(0, 1));
    endcase
    case (out_mode)
      0:       s_out.READY = 1'b0;
      1:       s_out.READY = 1'b1;
      2:       s_out.READY = ~s_out.READY;
      default: s_out.READY = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares whatever the DUT hands over against the scoreboard.
  always @(negedge clk) begin
    if (aresetn) begin
      if (s_out.VALID && s_out.READY) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_beat actual=unexpected_%0h required=none", s_out.DATA);
        end else begin
          beat_t b;
          b = bq.pop_front();
          chk("out_beat", 168'({s_out.DATA, s_out.KEEP, s_out.LAST}), 168'(b));
        end
      end
      if (hdr_valid && hdr_ready) begin
        if (hq.size() == 0) begin
          checks++; errors++;
          $display("FAIL hdr actual=unexpected_%0h required=none", mac_dst);
        end else begin
          hdr_t h;
          h = hq.pop_front();
          chk("hdr_fields",
              168'({mac_dst, mac_src, dst_rank, src_rank, packet_type, size, tag}),
              168'(h));
        end
      end
      if (err_trunc) seen_trunc++;
      if (err_len)   seen_len++;
    end
  end

  // Packet-level reference: fields by byte position, payload = beats after
  // the third, length error when the summed KEEP bytes differ from size.
  // cut>0 models only the beats below index cut (packet later aborted).
  task automatic model_pkt(input int cut);
    int n;
    hdr_t h;
    beat_t b;
    logic [63:0] b0, b1, b2;
    longint bytes;
    n = pd.size();
    if (n < 3) begin
      exp_trunc++;
      return;
    end
    b0 = pd[0]; b1 = pd[1]; b2 = pd[2];
    h.dst = b0[47:0];
    h.src = {b1[31:0], b0[63:48]};
    h.dr  = b1[47:32];
    h.sr  = b1[55:48];
    h.ty  = b1[63:56];
    h.sz  = b2[31:0];
    h.tg  = b2[39:32];
    hq.push_back(h);
    if (n == 3) begin
      if (h.sz != 32'd0) exp_len++;
      return;
    end
    if (h.ty == 8'hFF) return;
    bytes = 0;
    for (int i = 3; i < n; i++) begin
      if (cut > 0 && i >= cut) break;
      b.d = pd[i]; b.k = pk[i]; b.l = (i == n - 1);
      bq.push_back(b);
      bytes += longint'($countones(pk[i]));
    end
    if (cut == 0 && bytes[31:0] != h.sz) exp_len++;
  endtask

  // Called at posedge+1; returns at posedge+1 after the last beat accepted.
  task automatic drive_pkt(input int cut, input bit gaps);
    int n, t;
    bit acc;
    n = (cut > 0) ? cut : pd.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_in.VALID = 1'b0;
        @(posedge clk); #1;
      end
      s_in.VALID = 1'b1;
      s_in.DATA  = pd[i];
      s_in.KEEP  = pk[i];
      s_in.LAST  = (i == pd.size() - 1);
      t = 0; acc = 1'b0;
      while (!acc) begin
        @(negedge clk);
        acc = s_in.READY;
        @(posedge clk); #1;
        t++;
        if (!acc && t > 2000) begin
          checks++; errors++;
          $display("FAIL in_accept beat=%0d actual=stalled required=accepted", i);
          s_in.VALID = 1'b0;
          return;
        end
      end
    end
    s_in.VALID = 1'b0;
    s_in.LAST  = 1'b0;
  endtask

  task automatic build_hdr(input logic [47:0] dst, input logic [47:0] src,
                           input logic [15:0] dr, input logic [7:0] sr,
                           input logic [7:0] ty, input logic [31:0] sz,
                           input logic [7:0] tg);
    pd.delete(); pk.delete();
    pd.push_back({src[15:0], dst});
    pd.push_back({ty, sr, dr, src[47:16]});
    pd.push_back({24'($urandom()), tg, sz});
    for (int i = 0; i < 3; i++) pk.push_back(8'($urandom()));
  endtask

  task automatic add_beat(input logic [63:0] d, input logic [7:0] k);
    pd.push_back(d);
    pk.push_back(k);
  endtask

  task automatic send(input bit gaps);
    model_pkt(0);
    drive_pkt(0, gaps);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [47:0] saved_dst;
    s_in.VALID = 1'b0; s_in.DATA = '0; s_in.KEEP = '0; s_in.LAST = 1'b0;
    s_out.READY = 1'b1; hdr_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_hdr_valid", 168'(hdr_valid), 168'(0));
    chk("rst_in_ready", 168'(s_in.READY), 168'(0));
    chk("rst_out_valid", 168'(s_out.VALID), 168'(0));
    chk("rst_errs", 168'({err_trunc, err_len}), 168'(0));
    chk("rst_fields", 168'({mac_dst, mac_src, size}), 168'(0));
    #19 aresetn = 1'b1;
    @(posedge clk); #1;

    // Reference packet with the header held by the consumer
    hdr_mode = 0;
    build_hdr(48'h0cc47a88c047, 48'hfa163e55ca02, 16'd1, 8'd0, 8'd2, 32'd16, 8'd7);
    add_beat(64'h1122334455667788, 8'hFF);
    add_beat(64'h99aabbccddeeff00, 8'hFF);
    send(0);
    cycles(2);
    chk("ref_hdr_valid", 168'(hdr_valid), 168'(1));
    chk("ref_mac_dst", 168'(mac_dst), 168'(48'h0cc47a88c047));
    chk("ref_mac_src", 168'(mac_src), 168'(48'hfa163e55ca02));
    chk("ref_ranks_type", 168'({dst_rank, src_rank, packet_type}), 168'({16'd1, 8'd0, 8'd2}));
    chk("ref_size_tag", 168'({size, tag}), 168'({32'd16, 8'd7}));
    chk("ref_out_drained", 168'(bq.size()), 168'(0));

    // Next packet's beat0 must stall while the header is unconsumed
    saved_dst = mac_dst;
    build_hdr(48'h111122223333, 48'h444455556666, 16'd9, 8'd3, 8'd4, 32'd8, 8'd1);
    add_beat(64'hdeadbeefcafef00d, 8'hFF);
    model_pkt(0);
    s_in.VALID = 1'b1; s_in.DATA = pd[0]; s_in.KEEP = pk[0]; s_in.LAST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 168'(s_in.READY), 168'(0));
      chk("stall_mac_dst", 168'(mac_dst), 168'(saved_dst));
      @(posedge clk); #1;
    end
    hdr_mode = 1;
    drive_pkt(0, 0);
    cycles(3);

    // Length check: 12 bytes correct, then same payload claiming 16
    build_hdr(48'ha1, 48'hb2, 16'd2, 8'd1, 8'd3, 32'd12, 8'd5);
    add_beat(64'h0102030405060708, 8'hFF);
    add_beat(64'h0a0b0c0d0e0f1011, 8'h0F);
    send(0);
    cycles(3);
    chk("len_ok_count", 168'(seen_len), 168'(exp_len));
    build_hdr(48'ha1, 48'hb2, 16'd2, 8'd1, 8'd3, 32'd16, 8'd5);
    add_beat(64'h0102030405060708, 8'hFF);
    add_beat(64'h0a0b0c0d0e0f1011, 8'h0F);
    send(0);
    cycles(3);
    chk("len_bad_count", 168'(seen_len), 168'(exp_len));

    // Truncation on header beat1, then on beat0, then a clean packet
    build_hdr(48'hc3, 48'hd4, 16'd5, 8'd6, 8'd7, 32'd8, 8'd9);
    void'(pd.pop_back()); void'(pk.pop_back());
    send(0);
    cycles(3);
    chk("trunc_count", 168'(seen_trunc), 168'(exp_trunc));
    chk("trunc_no_hdr_valid", 168'(hdr_valid), 168'(0));
    build_hdr(48'hc3, 48'hd4, 16'd5, 8'd6, 8'd7, 32'd8, 8'd9);
    void'(pd.pop_back()); void'(pk.pop_back());
    void'(pd.pop_back()); void'(pk.pop_back());
    send(0);
    build_hdr(48'he5, 48'hf6, 16'd7, 8'd8, 8'd9, 32'd8, 8'd10);
    add_beat(64'h5555aaaa5555aaaa, 8'hFF);
    send(0);
    cycles(3);
    chk("trunc_count2", 168'(seen_trunc), 168'(exp_trunc));

    // Header-only packets, reserved type, non-contiguous keep
    build_hdr(48'h1, 48'h2, 16'd3, 8'd4, 8'd5, 32'd0, 8'd6);
    send(0);
    build_hdr(48'h1, 48'h2, 16'd3, 8'd4, 8'd5, 32'd5, 8'd6);
    send(0);
    build_hdr(48'h7, 48'h8, 16'd3, 8'd4, 8'hFF, 32'd99, 8'd6);
    add_beat(64'h1, 8'hFF); add_beat(64'h2, 8'hFF);
    send(0);
    build_hdr(48'h9, 48'ha, 16'd3, 8'd4, 8'd1, 32'd6, 8'd6);
    add_beat(64'h0123456789abcdef, 8'hA5); add_beat(64'hfedcba9876543210, 8'h81);
    send(0);
    cycles(3);
    chk("misc_len_count", 168'(seen_len), 168'(exp_len));

    // Output backpressure toggling every cycle over a 4-beat payload
    out_mode = 2;
    build_hdr(48'hbb, 48'hcc, 16'd1, 8'd2, 8'd3, 32'd32, 8'd4);
    for (int i = 0; i < 4; i++) add_beat(64'(64'h1000 + i), 8'hFF);
    send(0);
    cycles(4);
    chk("toggle_drained", 168'(bq.size()), 168'(0));
    out_mode = 1;

    // Reset while payload beat 2 is on the input
    build_hdr(48'hdd, 48'hee, 16'd1, 8'd2, 8'd3, 32'd32, 8'd4);
    for (int i = 0; i < 4; i++) add_beat(64'(64'h2000 + i), 8'hFF);
    model_pkt(5);
    drive_pkt(5, 0);
    s_in.VALID = 1'b1; s_in.DATA = pd[5]; s_in.KEEP = pk[5]; s_in.LAST = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    chk("arst_out_valid", 168'(s_out.VALID), 168'(0));
    chk("arst_in_ready", 168'(s_in.READY), 168'(0));
    chk("arst_hdr_valid", 168'(hdr_valid), 168'(0));
    chk("arst_fields", 168'({mac_dst, size, err_len, err_trunc}), 168'(0));
    s_in.VALID = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk); #1;
    chk("arst_scoreboard", 168'(bq.size() + hq.size()), 168'(0));
    build_hdr(48'h0cc47a88c047, 48'hfa163e55ca02, 16'd1, 8'd0, 8'd2, 32'd16, 8'd7);
    add_beat(64'h3333, 8'hFF); add_beat(64'h4444, 8'hFF);
    send(0);

    // Randomized traffic under random back-pressure
    hdr_mode = 3; out_mode = 3;
    for (int p = 0; p < 40; p++) begin
      logic [63:0] rd[$];
      logic [7:0]  rk[$];
      int np, bytes, cut;
      logic [31:0] sz;
      logic [7:0]  ty;
      np = $urandom_range(0, 5);
      bytes = 0;
      for (int i = 0; i < np; i++) begin
        rd.push_back({$urandom(), $urandom()});
        rk.push_back(($urandom_range(0, 2) != 0) ? 8'hFF : 8'($urandom()));
        bytes += $countones(rk[i]);
      end
      sz = ($urandom_range(0, 1) != 0) ? 32'(bytes) : 32'($urandom_range(0, 48));
      ty = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      build_hdr(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}),
                16'($urandom()), 8'($urandom()), ty, sz, 8'($urandom()));
      for (int i = 0; i < np; i++) add_beat(rd[i], rk[i]);
      if ($urandom_range(0, 9) == 0) begin
        cut = $urandom_range(1, 2);
        while (pd.size() > cut) begin
          void'(pd.pop_back()); void'(pk.pop_back());
        end
      end
      send(1);
    end

    // Drain and final tallies
    hdr_mode = 1; out_mode = 1;
    for (int t = 0; t < 2000 && (hq.size() != 0 || bq.size() != 0); t++) cycles(1);
    cycles(3);
    chk("final_hdr_queue", 168'(hq.size()), 168'(0));
    chk("final_beat_queue", 168'(bq.size()), 168'(0));
    chk("final_trunc_count", 168'(seen_trunc), 168'(exp_trunc));
    chk("final_len_count", 168'(seen_len), 168'(exp_len));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
